// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  // Arbiter sequencing: accept a request, strobe the RAM, then respond.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Port indices used for grant bookkeeping.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  // Native widths of the request bundle.
  localparam int REQ_ADDR_WIDTH = 32;
  localparam int REQ_DATA_WIDTH = 32;

  // One latched request: direction, byte address and write data.
  typedef struct packed {
    logic                      we;
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic [REQ_DATA_WIDTH-1:0] wdata;
  } req_t;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin on ties, or port 0 first when fixed.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       fixed,
  output logic [1:0] grant
);

  // A lone requester always wins; a tie goes to port 0 (fixed) or away from the last winner.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      if (fixed) begin
        grant = port_onehot(PORT_CPU);
      end else begin
        grant = port_onehot(~last_grant);
      end
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one byte-addressed, word-access RAM between the core (port 0) and a
// second master (port 1). One access per three cycles: accept, strobe, respond.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = REQ_DATA_WIDTH,
  parameter int ADDR_WIDTH     = REQ_ADDR_WIDTH,
  parameter int MEM_SIZE       = 1028,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Highest byte address at which a full word still fits in the RAM.
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ADDR_WIDTH'(MEM_SIZE - 4);

  arb_state_t state;
  arb_state_t state_next;

  logic       last_grant;
  logic       grant_port;
  logic       err_q;
  req_t       req_q;

  logic [1:0] pick;
  req_t       sel_req;
  logic       sel_in_range;
  logic       handshake;

  rr_pick2 u_pick (
    .valid      ({p1_req_valid, p0_req_valid}),
    .last_grant (last_grant),
    .fixed      (FIXED_PRIORITY),
    .grant      (pick)
  );

  // Only offer ready while idle and out of reset, and only to the picked port.
  assign p0_req_ready = reset && (state == IDLE) && pick[0];
  assign p1_req_ready = reset && (state == IDLE) && pick[1];
  assign handshake    = (state == IDLE) && (pick != 2'b00);

  // The response pulse goes to whichever port owns the access in flight.
  assign p0_rsp_valid = (state == RESP) && (grant_port == PORT_CPU);
  assign p1_rsp_valid = (state == RESP) && (grant_port == PORT_EXT);

  // Address and write data come straight from the latched request so they stay stable.
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // Route the picked port's request fields and judge its address against the RAM size.
  always_comb begin
    sel_req = '0;
    if (pick[1]) begin
      sel_req.we    = p1_req_we;
      sel_req.addr  = p1_req_addr;
      sel_req.wdata = p1_req_wdata;
    end else begin
      sel_req.we    = p0_req_we;
      sel_req.addr  = p0_req_addr;
      sel_req.wdata = p0_req_wdata;
    end
    sel_in_range = (sel_req.addr <= LAST_WORD_ADDR);
  end

  // State register; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a handshake starts the fixed accept/strobe/respond sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request, drive the one-cycle RAM strobe and capture the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= PORT_EXT;
      grant_port <= PORT_CPU;
      err_q      <= 1'b0;
      req_q      <= '0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            grant_port <= pick[1];
            last_grant <= pick[1];
            req_q      <= sel_req;
            err_q      <= !sel_in_range;
            mem_wen    <= sel_req.we && sel_in_range;
            mem_ren    <= !sel_req.we && sel_in_range;
          end
        end
        ACCESS: begin
          mem_wen <= 1'b0;
          mem_ren <= 1'b0;
          rsp_err <= err_q;
          if (err_q) begin
            rsp_rdata <= '0;
          end else if (!req_q.we) begin
            rsp_rdata <= mem_rdata;
          end
        end
        default: begin
          mem_wen <= 1'b0;
          mem_ren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-array RAM model and a word reference model.
module tb_ram_arbiter;

  localparam int MEM_BYTES = 1028;

  logic        clk;
  logic        reset;
  logic        p0_req_valid, p0_req_we, p1_req_valid, p1_req_we;
  logic [31:0] p0_req_addr, p0_req_wdata, p1_req_addr, p1_req_wdata;
  logic        p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fp_p0_req_ready, fp_p1_req_ready, fp_p0_rsp_valid, fp_p1_rsp_valid;
  logic [31:0] fp_rsp_rdata;
  logic        fp_rsp_err, fp_mem_wen, fp_mem_ren;
  logic [31:0] fp_mem_addr, fp_mem_wdata;
  logic [31:0] fp_mem_rdata;

  logic [7:0]  ram [0:MEM_BYTES-1];
  logic [31:0] ref_mem [0:256];

  int errors = 0;
  int checks = 0;

  ram_arbiter #(.MEM_SIZE(MEM_BYTES), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ram_arbiter #(.MEM_SIZE(MEM_BYTES), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(fp_p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(fp_p0_rsp_valid),
    .p1_req_valid(p1_req_valid), .p1_req_ready(fp_p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(fp_p1_rsp_valid),
    .rsp_rdata(fp_rsp_rdata), .rsp_err(fp_rsp_err),
    .mem_wen(fp_mem_wen), .mem_ren(fp_mem_ren), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
  );

  assign fp_mem_rdata = 32'h0;

  // 100 MHz-style clock, posedges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: acts on the negedge, little-endian bytes, registered read data.
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ram[i] = 8'h00;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_wen && mem_addr <= 32'(MEM_BYTES - 4)) begin
        for (int i = 0; i < 4; i++) ram[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
      end
      if (mem_ren && mem_addr <= 32'(MEM_BYTES - 4)) begin
        mem_rdata = {ram[mem_addr + 32'd3], ram[mem_addr + 32'd2],
                     ram[mem_addr + 32'd1], ram[mem_addr]};
      end
    end
  end

  // Strobe monitor: never both strobes, and no strobe longer than one cycle.
  initial begin
    logic prev_wen, prev_ren;
    prev_wen = 1'b0;
    prev_ren = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && (mem_wen || mem_ren)) begin
        checks++;
        if ((mem_wen && mem_ren) || (mem_wen && prev_wen) || (mem_ren && prev_ren)) begin
          errors++;
          $display("[TB] FAIL strobe_shape: wen=%0b ren=%0b prev_wen=%0b prev_ren=%0b required single one-cycle strobe",
                   mem_wen, mem_ren, prev_wen, prev_ren);
        end
      end
      prev_wen = mem_wen;
      prev_ren = mem_ren;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, complete the handshake; returns in the ACCESS cycle.
  task automatic send(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int   waited;
    logic my_ready;
    logic other_ready;
    if (port == 0) begin
      p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
    end else begin
      p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
    end
    #1;
    waited   = 0;
    my_ready = (port == 0) ? p0_req_ready : p1_req_ready;
    while (!my_ready && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
      my_ready = (port == 0) ? p0_req_ready : p1_req_ready;
    end
    other_ready = (port == 0) ? p1_req_ready : p0_req_ready;
    checks++;
    if (!my_ready || other_ready) begin
      errors++;
      $display("[TB] FAIL send_ready port=%0d: ready=%0b other_ready=%0b required ready=1 other_ready=0",
               port, my_ready, other_ready);
    end
    if (my_ready) @(posedge clk);
    #1;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'h0; p0_req_wdata = 32'h0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h0; p1_req_wdata = 32'h0;
    next_cycle();
    next_cycle();
    checks++;
    if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: p0=%0b p1=%0b required 0 0", p0_req_ready, p1_req_ready);
    end
    checks++;
    if (mem_wen !== 1'b0 || mem_ren !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem: wen=%0b ren=%0b addr=%h wdata=%h required all 0",
               mem_wen, mem_ren, mem_addr, mem_wdata);
    end
    checks++;
    if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: v0=%0b v1=%0b rdata=%h err=%0b required all 0",
               p0_rsp_valid, p1_rsp_valid, rsp_rdata, rsp_err);
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_write();
    send(0, 1'b1, 32'h138, 32'hDEADBEEF);
    ref_mem[32'h138 >> 2] = 32'hDEADBEEF;
    checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 32'h138 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_strobe: wen=%0b ren=%0b addr=%h wdata=%h required 1 0 00000138 deadbeef",
               mem_wen, mem_ren, mem_addr, mem_wdata);
    end
    checks++;
    if (p0_rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_early_rsp: p0_rsp_valid=%0b required 0", p0_rsp_valid);
    end
    next_cycle();
    checks++;
    if (p0_rsp_valid !== 1'b1 || p1_rsp_valid !== 1'b0 || mem_wen !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_rsp: v0=%0b v1=%0b wen=%0b err=%0b required 1 0 0 0",
               p0_rsp_valid, p1_rsp_valid, mem_wen, rsp_err);
    end
    checks++;
    if (ram[32'h138] !== 8'hEF || ram[32'h139] !== 8'hBE || ram[32'h13A] !== 8'hAD || ram[32'h13B] !== 8'hDE) begin
      errors++;
      $display("[TB] FAIL write_bytes: got %h %h %h %h required ef be ad de",
               ram[32'h138], ram[32'h139], ram[32'h13A], ram[32'h13B]);
    end
    next_cycle();
  endtask

  task automatic test_read();
    send(1, 1'b0, 32'h138, 32'h0);
    checks++;
    if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 32'h138) begin
      errors++;
      $display("[TB] FAIL read_strobe: ren=%0b wen=%0b addr=%h required 1 0 00000138", mem_ren, mem_wen, mem_addr);
    end
    next_cycle();
    checks++;
    if (p1_rsp_valid !== 1'b1 || p0_rsp_valid !== 1'b0 || mem_ren !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_rsp_valid: v1=%0b v0=%0b ren=%0b required 1 0 0", p1_rsp_valid, p0_rsp_valid, mem_ren);
    end
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_data: rdata=%h err=%0b required deadbeef 0", rsp_rdata, rsp_err);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic exp_p0_ready, exp_p1_ready, exp_p0_rsp, exp_p1_rsp;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'h138; p0_req_wdata = 32'h0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h138; p1_req_wdata = 32'h0;
    #1;
    for (int c = 0; c < 12; c++) begin
      exp_p0_ready = (c % 6 == 0);
      exp_p1_ready = (c % 6 == 3);
      exp_p0_rsp   = (c % 6 == 2);
      exp_p1_rsp   = (c % 6 == 5);
      checks++;
      if (p0_req_ready !== exp_p0_ready || p1_req_ready !== exp_p1_ready) begin
        errors++;
        $display("[TB] FAIL rr_grant c=%0d: ready=%0b%0b required %0b%0b",
                 c, p0_req_ready, p1_req_ready, exp_p0_ready, exp_p1_ready);
      end
      checks++;
      if (p0_rsp_valid !== exp_p0_rsp || p1_rsp_valid !== exp_p1_rsp) begin
        errors++;
        $display("[TB] FAIL rr_rsp c=%0d: rsp=%0b%0b required %0b%0b",
                 c, p0_rsp_valid, p1_rsp_valid, exp_p0_rsp, exp_p1_rsp);
      end
      checks++;
      if (fp_p1_req_ready !== 1'b0 || fp_p0_req_ready !== (c % 3 == 0)) begin
        errors++;
        $display("[TB] FAIL fixed_grant c=%0d: ready=%0b%0b required %0b0",
                 c, fp_p0_req_ready, fp_p1_req_ready, (c % 3 == 0));
      end
      next_cycle();
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_range_error();
    send(0, 1'b0, 32'h401, 32'h0);
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_strobe_401: ren=%0b wen=%0b required 0 0", mem_ren, mem_wen);
    end
    next_cycle();
    checks++;
    if (p0_rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL range_rsp_401: v0=%0b err=%0b rdata=%h required 1 1 00000000",
               p0_rsp_valid, rsp_err, rsp_rdata);
    end
    next_cycle();
    send(0, 1'b0, 32'hFFFFFFFE, 32'h0);
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_strobe_wrap: ren=%0b wen=%0b required 0 0", mem_ren, mem_wen);
    end
    next_cycle();
    checks++;
    if (p0_rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL range_rsp_wrap: v0=%0b err=%0b rdata=%h required 1 1 00000000",
               p0_rsp_valid, rsp_err, rsp_rdata);
    end
    next_cycle();
    send(0, 1'b0, 32'h400, 32'h0);
    checks++;
    if (mem_ren !== 1'b1 || mem_addr !== 32'h400) begin
      errors++;
      $display("[TB] FAIL range_last_word_strobe: ren=%0b addr=%h required 1 00000400", mem_ren, mem_addr);
    end
    next_cycle();
    checks++;
    if (p0_rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_last_word_rsp: v0=%0b err=%0b required 1 0", p0_rsp_valid, rsp_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    send(1, 1'b1, 32'h40, 32'h12345678);
    checks++;
    if (mem_wen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre_wen: wen=%0b required 1", mem_wen);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_wen !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_async: wen=%0b addr=%h required 0 00000000", mem_wen, mem_addr);
    end
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'h0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      checks++;
      if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 || p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_held c=%0d: rsp=%0b%0b ready=%0b%0b required 00 00",
                 c, p0_rsp_valid, p1_rsp_valid, p0_req_ready, p1_req_ready);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_first_tie: ready=%0b%0b required 10", p0_req_ready, p1_req_ready);
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      checks++;
      if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 || mem_wen !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_after c=%0d: rsp=%0b%0b wen=%0b required 00 0",
                 c, p0_rsp_valid, p1_rsp_valid, mem_wen);
      end
    end
    checks++;
    if ({ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_ram: word=%h required 00000000",
               {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]});
    end
  endtask

  task automatic test_random();
    int          port;
    logic        we, ok;
    logic [31:0] addr, wdata, exp_rdata;
    logic        got_v0, got_v1;
    exp_rdata = 32'h0;
    for (int n = 0; n < 30; n++) begin
      port  = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      case ($urandom_range(0, 7))
        0:       addr = 32'h404 + {$urandom_range(0, 255), 2'b00};
        1:       addr = 32'hFFFFFFFC;
        default: addr = {20'h0, 2'b00, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      if ($urandom_range(0, 9) == 0) addr = 32'h400;
      ok = (addr <= 32'h400);
      send(port, we, addr, wdata);
      checks++;
      if (mem_wen !== (we && ok) || mem_ren !== (!we && ok)) begin
        errors++;
        $display("[TB] FAIL rand_strobe n=%0d: wen=%0b ren=%0b required %0b %0b",
                 n, mem_wen, mem_ren, we && ok, !we && ok);
      end
      if (!ok) begin
        exp_rdata = 32'h0;
      end else if (we) begin
        ref_mem[addr[10:2]] = wdata;
      end else begin
        exp_rdata = ref_mem[addr[10:2]];
      end
      next_cycle();
      got_v0 = p0_rsp_valid;
      got_v1 = p1_rsp_valid;
      checks++;
      if (got_v0 !== (port == 0) || got_v1 !== (port == 1) || rsp_err !== !ok || rsp_rdata !== exp_rdata) begin
        errors++;
        $display("[TB] FAIL rand_rsp n=%0d: rsp=%0b%0b err=%0b rdata=%h required %0b%0b %0b %h",
                 n, got_v0, got_v1, rsp_err, rsp_rdata, port == 0, port == 1, !ok, exp_rdata);
      end
      next_cycle();
    end
  endtask

  // Main sequence.
  initial begin
    for (int i = 0; i <= 256; i++) ref_mem[i] = 32'h0;
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = 32'h0; p0_req_wdata = 32'h0;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = 32'h0; p1_req_wdata = 32'h0;
    reset = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_range_error();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter that shares one byte-addressed, word-access RAM between the NK0W0 core (port 0) and a second bus master (port 1, e.g. program loader or DMA).
- Sits between the masters and the RAM model. The RAM samples `wen`/`ren` on the negedge and returns registered read data before the next posedge.
- Adds valid/ready request and response handshakes, round-robin or fixed priority, and address-range checking.

Parameters:
- DATA_WIDTH, 32, word width of the request, response and RAM data.
- ADDR_WIDTH, 32, byte address width.
- MEM_SIZE, 1028, RAM size in bytes; a word access is legal iff addr <= MEM_SIZE-4.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- p0_req_valid  in  1  port 0 request present.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_we  in  1  1 = write, 0 = read.
- p0_req_addr  in  ADDR_WIDTH  byte address.
- p0_req_wdata  in  DATA_WIDTH  write data.
- p0_rsp_valid  out  1  one-cycle completion pulse for port 0.
- p1_req_valid, p1_req_ready, p1_req_we, p1_req_addr, p1_req_wdata, p1_rsp_valid  same as port 0, for port 1.
- rsp_rdata  out  DATA_WIDTH  read data; valid with the rsp_valid pulse.
- rsp_err  out  1  out-of-range flag; valid with the rsp_valid pulse.
- mem_wen  out  1  RAM write enable.
- mem_ren  out  1  RAM read enable.
- mem_addr  out  ADDR_WIDTH  RAM byte address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All outputs are 0: ready, rsp_valid, rsp_rdata, rsp_err, mem_*.
  - Any in-flight access is dropped and produces no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - The winner is chosen combinationally from the req_valid inputs.
  - req_ready is asserted for the winner only; ready is never asserted for both ports.
  - Handshake = valid & ready at the posedge. At that edge: latch grant, we, addr and wdata, then go to ACCESS.
  - mem_wen/mem_ren are registered: mem_wen=we, mem_ren=!we. Both stay 0 if the address is out of range.
- ACCESS (exactly 1 cycle):
  - mem_* held stable; the RAM acts on the negedge.
  - At the posedge: rsp_rdata<=mem_rdata for reads (held for writes), rsp_err<=range fault, mem_wen/mem_ren<=0, go to RESP.
- RESP (1 cycle):
  - Granted port's rsp_valid=1. rsp_rdata and rsp_err are valid.
  - No ready is asserted. Next state is IDLE.
- Latency and throughput:
  - Handshake at end of cycle T; memory strobe in T+1; rsp_valid in T+2.
  - Maximum one access per 3 cycles. There is no response backpressure: masters must always accept rsp_valid.
- Arbitration:
  - Round-robin: on a tie, grant the port ≠ last_grant. last_grant is updated on each handshake.
  - FIXED_PRIORITY=1: port 0 wins every tie and last_grant is ignored.
  - A single requester is always granted.
- Range error: a request with addr > MEM_SIZE-4 (including the unsigned wrap of addr+3) is accepted, never drives mem_wen/mem_ren, and responds with rsp_err=1, rsp_rdata=0.
- Request hold: masters hold req fields stable while valid and not ready. Dropping valid before ready is allowed; nothing is recorded.
- Write response: writes also produce an rsp_valid acknowledge, with rsp_rdata unchanged.
- Simultaneous events: a new request arriving while in ACCESS/RESP waits, and is arbitrated in IDLE against the other port's request.
- Invariants: mem_wen and mem_ren are never 1 together. Each mem strobe lasts exactly one cycle.

Decomposition:
- Shared package `ram_arb_pkg`:
  - state enum (IDLE/ACCESS/RESP);
  - port index constants PORT_CPU=0, PORT_EXT=1;
  - typedef for the request bundle {we, addr, wdata}.
- One sub-module, `rr_pick2`: a combinational 2-way round-robin/fixed-priority picker. Inputs: valid[1:0], last_grant, fixed. Output: one-hot grant.
- The FSM and registers stay in `ram_arbiter`.

Test Plan:
- Reset, then p0 write addr=0x138 data=0xDEADBEEF → p0_req_ready in the request cycle. mem_wen=1 for one cycle with mem_addr=0x138. p0_rsp_valid two cycles after the handshake. RAM bytes 0x138..0x13B = EF,BE,AD,DE.
- p1 read addr=0x138 after the previous write → mem_ren pulse one cycle. p1_rsp_valid=1 with rsp_rdata=0xDEADBEEF and rsp_err=0. p0_rsp_valid stays 0.
- Both ports hold valid continuously, round-robin → grants alternate p0,p1,p0,p1, with one rsp every 3 cycles. With FIXED_PRIORITY=1, p1 is never granted while p0 is valid.
- p0 read addr=0x401 (MEM_SIZE=1028) → no mem_ren/mem_wen, rsp_err=1, rsp_rdata=0. Also p0 read addr=0xFFFFFFFE → rsp_err=1.
- Assert reset low asynchronously in the ACCESS cycle of a p1 write → mem_wen drops immediately and no rsp_valid is ever produced. After release, the first tie goes to p0.
- Random mixed traffic on both ports against a reference memory model → all read data match, no overlapping strobes, and wen&ren is never 1.
